// File: rtl/instr_encode.sv
// rtl/instr_encode.sv - packs I/S-type immediates into 32-bit instructions behind a two-entry FIFO.
// Optional immediate range check enabled by defining INSTR_ENCODE_RANGE_CHECK_EN.
module instr_encode (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [32:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [7:0]  r_err_count;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_enc;
  logic        w_err;
`ifdef INSTR_ENCODE_RANGE_CHECK_EN
  logic        w_range_bad;
`endif

  always_comb begin
    w_enc = '0;
    w_err = 1'b0;
    case (imm_src)
      2'b00:   w_enc = {imm[11:0], rs1, funct3, rd, opcode};
      2'b01:   w_enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      default: begin
        w_enc = {12'b0, rs1, funct3, rd, opcode};
        w_err = 1'b1;
      end
    endcase
`ifdef INSTR_ENCODE_RANGE_CHECK_EN
    // A 12-bit field is exact only when bits 31..11 are a pure sign extension.
    w_range_bad = !((&imm[31:11]) || !(|imm[31:11]));
    if (!imm_src[1] && w_range_bad) begin
      w_err = 1'b1;
    end
`endif
  end

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_push) w_state_nxt = ONE;
      ONE: begin
        if (w_push && !w_pop) begin
          w_state_nxt = FULL;
        end else if (w_pop && !w_push) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL:    if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_err, w_enc};
        r_wr_ptr        <= ~r_wr_ptr;
        if (w_err && (r_err_count != 8'hFF)) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
    end
  end

  // Head entry drives the outputs directly, so they hold while the consumer stalls.
  assign {out_err, instr} = r_mem[r_rd_ptr];
  assign err_count        = r_err_count;

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  request word present.
REQ-004 in_ready  output  1  block can accept a request (= buffer not full).
REQ-005 imm_src  input  2  immediate format: 00 I-type, 01 S-type, 1x invalid.
REQ-006 imm  input  32  signed immediate to pack.
REQ-007 opcode  input  7  instr[6:0].
REQ-008 rd  input  5  instr[11:7], I-type only; ignored for S-type.
REQ-009 funct3  input  3  instr[14:12].
REQ-010 rs1  input  5  instr[19:15].
REQ-011 rs2  input  5  instr[24:20], S-type only; ignored for I-type.
REQ-012 out_valid  output  1  encoded word available.
REQ-013 out_ready  input  1  consumer takes word when out_valid & out_ready.
REQ-014 instr  output  32  encoded instruction.
REQ-015 out_err  output  1  error flag travelling with instr.
REQ-016 err_count  output  8  saturating count of accepted errored requests.

Function
REQ-017 Accept on in_valid & in_ready at a rising edge; deliver on out_valid & out_ready at a rising edge.
REQ-018 I-type packing: instr = {imm[11:0], rs1, funct3, rd, opcode}.
REQ-019 S-type packing: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-020 Invalid imm_src: I-type layout with imm field 12'b0, out_err = 1.
REQ-021 Packing is round-trip exact: the sign-extended immediate decoded from instr[31:7] for the same format equals imm whenever imm[31:11] are all equal.
REQ-022 Two-entry in-order FIFO; states EMPTY (0), ONE (1), FULL (2).
REQ-023 Transitions: push only -> count+1; pop only -> count-1; push and pop in ONE -> stays ONE; push impossible in FULL; pop in EMPTY impossible.
REQ-024 in_ready = (state != FULL), combinational from state only; out_valid = (state != EMPTY), registered.
REQ-025 Latency: word accepted at edge N is visible on instr/out_valid after edge N when it is at the FIFO head.
REQ-026 instr and out_err stay stable while out_valid & !out_ready.
REQ-027 In FULL with a pop, in_ready stays low that cycle; the next push is accepted no earlier than the following edge.
REQ-028 err_count increments by 1 at acceptance of any request whose out_err is 1; it saturates at 255 and never wraps.

Reset
REQ-029 reset asserted: immediately state = EMPTY, out_valid = 0, instr = 0, out_err = 0, err_count = 0, in_ready = 1; buffered words are discarded.
REQ-030 reset asserted mid-transfer: no handshake completes on any edge while reset is high.
REQ-031 First accept is possible at the first rising edge after reset deasserts.

Configuration
REQ-032 Macro INSTR_ENCODE_RANGE_CHECK_EN defined: I/S request with imm[31:11] not all equal sets out_err = 1; instr is still emitted with truncated imm[11:0].
REQ-033 Macro undefined: no range check; imm truncated silently; out_err = 1 only for invalid imm_src.

Verification
REQ-034 I-type: imm=0xFFFFFFFF, rs1=2, funct3=0, rd=1, opcode=0x13 -> instr=0xFFF10093, out_err=0, err_count=0.
REQ-035 S-type: imm=8, rs2=5, rs1=2, funct3=2, opcode=0x23 -> instr=0x00512423, out_err=0.
REQ-036 Range: fields as REQ-034 with imm=0x00000800 -> instr=0x80010093 in both builds. With macro: out_err=1, err_count=1. Without macro: out_err=0, err_count=0.
REQ-037 Backpressure: out_ready=0, offer A,B,C -> A,B accepted, in_ready=0, C held. Raise out_ready -> outputs A,B,C in order, with no duplicate or loss.
REQ-038 Reset mid-op: FIFO FULL, assert reset asynchronously -> out_valid=0 and in_ready=1 before the next edge, err_count=0.
REQ-039 Saturation: 300 accepted requests with imm_src=2'b10 -> err_count=255 and held.
